// File: rtl/mul_div_scheduler.sv
// Multiply/divide issue scheduler: stalls the front end while a
// multi-cycle mul/div runs and handles load-use hazard bubbles.
// Ports: clk, Rst (sync, active-high); ID_EX_* / IF_ID_* hazard inputs,
// divisor_zero, flush; mul/div start and ready pulses, md_rd, div_by_zero,
// abort, stall, bubble.
// Optional feature macro: DIV_ZERO_FAST_EN (divide by zero completes
// in one cycle without starting the divider).
module mul_div_scheduler #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 33
) (
   input  logic       clk,
   input  logic       Rst,
   input  logic       ID_EX_mul,
   input  logic       ID_EX_div,
   input  logic [4:0] ID_EX_rd,
   input  logic       ID_EX_memread,
   input  logic [4:0] IF_ID_rs1,
   input  logic [4:0] IF_ID_rs2,
   input  logic       divisor_zero,
   input  logic       flush,
   output logic       mul_start,
   output logic       div_start,
   output logic       mul_ready,
   output logic       div_ready,
   output logic [4:0] md_rd,
   output logic       div_by_zero,
   output logic       abort,
   output logic       stall,
   output logic       bubble
);

   typedef enum logic [1:0] {
      IDLE,
      MUL_RUN,
      DIV_RUN,
      DONE
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic [4:0] md_rd_q, md_rd_d;
   logic       op_div_q, op_div_d;
   logic       dz_q, dz_d;
   logic       busy;
   logic       load_use;

   always_ff @(posedge clk) begin
      if (Rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         md_rd_q  <= '0;
         op_div_q <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         md_rd_q  <= md_rd_d;
         op_div_q <= op_div_d;
         dz_q     <= dz_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      md_rd_d   = md_rd_q;
      op_div_d  = op_div_q;
      dz_d      = dz_q;
      mul_start = 1'b0;
      div_start = 1'b0;
      mul_ready = 1'b0;
      div_ready = 1'b0;
      abort     = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE: begin
            // flush kills the request before it is accepted
            if (!flush) begin
               if (ID_EX_mul) begin
                  busy      = 1'b1;
                  mul_start = 1'b1;
                  cnt_d     = 6'(MUL_LAT - 1);
                  md_rd_d   = ID_EX_rd;
                  op_div_d  = 1'b0;
                  dz_d      = 1'b0;
                  state_d   = MUL_RUN;
               end else if (ID_EX_div) begin
                  busy     = 1'b1;
                  md_rd_d  = ID_EX_rd;
                  op_div_d = 1'b1;
`ifdef DIV_ZERO_FAST_EN
                  if (divisor_zero) begin
                     dz_d    = 1'b1;
                     cnt_d   = '0;
                     state_d = DONE;
                  end else
`endif
                  begin
                     dz_d      = 1'b0;
                     div_start = 1'b1;
                     cnt_d     = 6'(DIV_LAT - 1);
                     state_d   = DIV_RUN;
                  end
               end
            end
         end
         MUL_RUN, DIV_RUN: begin
            busy = 1'b1;
            if (flush) begin
               abort   = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == 6'd0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (flush) begin
               abort = 1'b1;
               cnt_d = '0;
            end else begin
               mul_ready = !op_div_q;
               div_ready = op_div_q;
            end
         end
         default: state_d = IDLE;
      endcase
      // the reset cycle drops the in-flight op without any pulse
      if (Rst) begin
         mul_start = 1'b0;
         div_start = 1'b0;
         mul_ready = 1'b0;
         div_ready = 1'b0;
         abort     = 1'b0;
         busy      = 1'b0;
      end
   end

   assign load_use = ID_EX_memread && (ID_EX_rd != 5'd0) &&
                     ((ID_EX_rd == IF_ID_rs1) ||
                      (ID_EX_rd == IF_ID_rs2));
   assign stall  = busy || load_use;
   assign bubble = load_use && !busy;
   assign md_rd  = Rst ? 5'd0 : md_rd_q;

`ifdef DIV_ZERO_FAST_EN
   assign div_by_zero = div_ready && dz_q;
`else
   logic unused_dz;
   assign unused_dz   = divisor_zero ^ dz_q;
   assign div_by_zero = 1'b0;
`endif

endmodule
